// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester round-robin arbiter and sequencer for the
// single-port 1024x32 data memory (DM).
//
// Every access runs IDLE -> ACCESS -> RESP. The winner's request is latched
// in IDLE. The DM is driven in ACCESS, and the winner is acked in RESP.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN, weN, addrN, wdataN   requester N access request (N = 0, 1)
//   lockN                      requester N lock request
//   ackN, rdataN               requester N completion pulse and read data
//   dm_addr, dm_din, dm_DMWr   DM address, write data and write enable
//   dm_dout                    DM combinational read data
//   busy                       high whenever the sequencer is not IDLE
//
// Optional feature: `define DM_ARB_LOCK_EN enables lock ownership.
// Without it, lock0/lock1 are ignored and arbitration is pure round-robin.
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_DMWr,
  input  logic [DW-1:0] dm_dout,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_gnt_q, last_gnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          win;

  // Requests that take part in arbitration this cycle.
  logic          req0_eff, req1_eff;

`ifdef DM_ARB_LOCK_EN
  logic          lock_vld_q, lock_vld_d;
  logic          lock_id_q, lock_id_d;

  // While a lock owner exists, the other port is masked in IDLE.
  // If the owner has dropped its req, ownership ends and normal
  // arbitration applies in that same IDLE cycle.
  always_comb begin
    req0_eff   = req0;
    req1_eff   = req1;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (state_q == IDLE && lock_vld_q) begin
      if (lock_id_q ? req1 : req0) begin
        if (lock_id_q) req0_eff = 1'b0;
        else           req1_eff = 1'b0;
      end else begin
        lock_vld_d = 1'b0;
      end
    end
    if (state_q == RESP) begin
      lock_vld_d = gnt_q ? lock1 : lock0;
      lock_id_d  = gnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
  assign req0_eff    = req0;
  assign req1_eff    = req1;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_gnt_d = last_gnt_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    win        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_eff || req1_eff) begin
          // On a tie, the port not granted last time wins.
          win        = (req0_eff && req1_eff) ? ~last_gnt_q : req1_eff;
          gnt_d      = win;
          last_gnt_d = win;
          we_d       = win ? we1    : we0;
          addr_d     = win ? addr1  : addr0;
          wdata_d    = win ? wdata1 : wdata0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (gnt_q) rdata1_d = dm_dout;
          else       rdata0_d = dm_dout;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_gnt_q <= 1'b1;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_gnt_q <= last_gnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // The write enable is decoded from the state register. An asynchronous
  // reset during ACCESS therefore drops it at once.
  assign dm_DMWr = (state_q == ACCESS) && we_q;
  assign dm_addr = addr_q;
  assign dm_din  = wdata_q;
  assign ack0    = (state_q == RESP) && !gnt_q;
  assign ack1    = (state_q == RESP) && gnt_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter with a behavioural DM.
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          ack0, ack1, dm_DMWr, busy;
  logic [DW-1:0] rdata0, rdata1, dm_din, dm_dout;
  logic [AW-1:0] dm_addr;

  logic [DW-1:0] dm     [1024];
  logic [DW-1:0] shadow [1024];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            port;
    logic [DW-1:0] rdata;
    logic          chk_rd;
  } exp_t;
  exp_t sb[$];

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .ack1(ack1), .rdata1(rdata1),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_DMWr(dm_DMWr), .dm_dout(dm_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign dm_dout = dm[dm_addr];
  always @(posedge clk) if (dm_DMWr) dm[dm_addr] <= dm_din;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for an ack, sampling at negedges. Reports the acked
  // port (-1 timeout, 2 both), cycles waited, and write-enable activity.
  task automatic wait_ack(output int port, output int cyc, output int wr_cnt,
                          output logic [AW-1:0] wr_addr, output logic [DW-1:0] wr_data);
    port = -1; cyc = 0; wr_cnt = 0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (dm_DMWr) begin
        wr_cnt++;
        wr_addr = dm_addr;
        wr_data = dm_din;
      end
      if (ack0 || ack1) begin
        port = (ack0 && ack1) ? 2 : (ack0 ? 0 : 1);
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({ack0, ack1} !== 2'b00) begin
      errors++; $display("FAIL reset_ack: got %b required 00", {ack0, ack1});
    end
    checks++; if (dm_DMWr !== 1'b0) begin
      errors++; $display("FAIL reset_dmwr: got %b required 0", dm_DMWr);
    end
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b required 0", busy);
    end
    checks++; if ({dm_addr, dm_din} !== '0) begin
      errors++; $display("FAIL reset_dm_bus: got addr %h din %h required 0", dm_addr, dm_din);
    end
    checks++; if ({rdata0, rdata1} !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h %h required 0", rdata0, rdata1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    exp_t e; int p, cyc, wc; logic [AW-1:0] wa; logic [DW-1:0] wd; logic [DW-1:0] prev0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h005; wdata0 = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;
    sb.push_back('{0, '0, 1'b0});
    wait_ack(p, cyc, wc, wa, wd);
    e = sb.pop_front();
    req0 = 1'b0;
    checks++; if (p !== e.port) begin
      errors++; $display("FAIL wr_port: got %0d required %0d", p, e.port);
    end
    checks++; if (cyc !== 2) begin
      errors++; $display("FAIL wr_latency: got %0d required 2", cyc);
    end
    checks++; if (wc !== 1) begin
      errors++; $display("FAIL wr_dmwr_cycles: got %0d required 1", wc);
    end
    checks++; if (wa !== 10'h005) begin
      errors++; $display("FAIL wr_addr: got %h required 005", wa);
    end
    checks++; if (wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_data: got %h required deadbeef", wd);
    end
    @(negedge clk);

    prev0 = rdata0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h005;
    sb.push_back('{1, shadow[5], 1'b1});
    wait_ack(p, cyc, wc, wa, wd);
    e = sb.pop_front();
    req1 = 1'b0;
    checks++; if (p !== e.port) begin
      errors++; $display("FAIL rd_port: got %0d required %0d", p, e.port);
    end
    checks++; if (rdata1 !== e.rdata) begin
      errors++; $display("FAIL rd_data: got %h required %h", rdata1, e.rdata);
    end
    checks++; if (rdata0 !== prev0) begin
      errors++; $display("FAIL rd_other_rdata: got %h required %h", rdata0, prev0);
    end
    checks++; if (wc !== 0) begin
      errors++; $display("FAIL rd_no_write: got %0d required 0", wc);
    end
    repeat (2) @(negedge clk);
    checks++; if (rdata1 !== e.rdata) begin
      errors++; $display("FAIL rd_hold: got %h required %h", rdata1, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int p, cyc, wc; logic [AW-1:0] wa; logic [DW-1:0] wd;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h003;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h007;
    for (int k = 0; k < 4; k++)
      sb.push_back('{k % 2, ((k % 2) == 0) ? shadow[3] : shadow[7], 1'b1});
    for (int k = 0; k < 4; k++) begin
      wait_ack(p, cyc, wc, wa, wd);
      e = sb.pop_front();
      checks++; if (p !== e.port) begin
        errors++;
        $display("FAIL b2b_port[%0d]: got %0d required %0d", k, p, e.port);
      end
      checks++; if (cyc !== ((k == 0) ? 2 : 3)) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d required %0d", k, cyc, (k == 0) ? 2 : 3);
      end
      checks++; if (((e.port == 0) ? rdata0 : rdata1) !== e.rdata) begin
        errors++;
        $display("FAIL b2b_rdata[%0d]: got %h required %h", k,
                 (e.port == 0) ? rdata0 : rdata1, e.rdata);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    exp_t e; int p, cyc, wc; logic [AW-1:0] wa; logic [DW-1:0] wd; logic saw;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h010; wdata1 = 32'hCAFEF00D;
    shadow[16] = 32'hCAFEF00D;
    sb.push_back('{1, '0, 1'b0});
    wait_ack(p, cyc, wc, wa, wd);
    e = sb.pop_front();
    req1 = 1'b0;
    checks++; if (p !== e.port) begin
      errors++; $display("FAIL preload_port: got %0d required %0d", p, e.port);
    end
    @(negedge clk);

    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h010; wdata0 = 32'h12345678;
    @(negedge clk);
    checks++; if (dm_DMWr !== 1'b1) begin
      errors++; $display("FAIL rst_access_dmwr: got %b required 1", dm_DMWr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dm_DMWr !== 1'b0) begin
      errors++; $display("FAIL rst_async_dmwr: got %b required 0", dm_DMWr);
    end
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_async_busy: got %b required 0", busy);
    end
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack0 || ack1) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin
      errors++; $display("FAIL rst_no_ack: got %b required 0", saw);
    end
    req0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rdata0 !== '0) begin
      errors++; $display("FAIL rst_rdata0: got %h required 0", rdata0);
    end
  endtask

  task automatic test_single_req1();
    exp_t e; int p, cyc, wc; logic [AW-1:0] wa; logic [DW-1:0] wd;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h010;
    sb.push_back('{1, shadow[16], 1'b1});
    wait_ack(p, cyc, wc, wa, wd);
    e = sb.pop_front();
    req1 = 1'b0;
    checks++; if (p !== e.port) begin
      errors++; $display("FAIL single1_port: got %0d required %0d", p, e.port);
    end
    checks++; if (cyc !== 2) begin
      errors++; $display("FAIL single1_latency: got %0d required 2", cyc);
    end
    checks++; if (rdata1 !== e.rdata) begin
      errors++; $display("FAIL single1_rdata: got %h required %h", rdata1, e.rdata);
    end
    @(negedge clk);
  endtask

  // lock0 is held for the first two accesses of port 0 and released during
  // its third, so with locking the grant order is 0,0,0,1.
  task automatic test_lock();
    exp_t e; int p, cyc, wc; logic [AW-1:0] wa; logic [DW-1:0] wd; int n0;
    int order [4];
`ifdef DM_ARB_LOCK_EN
    order = '{0, 0, 0, 1};
`else
    order = '{0, 1, 0, 1};
`endif
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h003; lock0 = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h007; lock1 = 1'b0;
    for (int k = 0; k < 4; k++)
      sb.push_back('{order[k], (order[k] == 0) ? shadow[3] : shadow[7], 1'b1});
    n0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(p, cyc, wc, wa, wd);
      e = sb.pop_front();
      checks++; if (p !== e.port) begin
        errors++;
        $display("FAIL lock_port[%0d]: got %0d required %0d", k, p, e.port);
      end
      checks++; if (((e.port == 0) ? rdata0 : rdata1) !== e.rdata) begin
        errors++;
        $display("FAIL lock_rdata[%0d]: got %h required %h", k,
                 (e.port == 0) ? rdata0 : rdata1, e.rdata);
      end
      if (p == 0) n0++;
      if (n0 == 2 && lock0) begin
        @(negedge clk);
        lock0 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm[i]     = 32'hA5000000 | 32'(i);
      shadow[i] = 32'hA5000000 | 32'(i);
    end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_access();
    test_single_req1();
    test_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
